vga_timing_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA raster timing from the board clock.
- Provides pixel coordinates (x, y) to the downstream pixel pattern stage, which maps coordinates to pixel_on.
- Provides hsync, vsync and video_on to the DAC/output stage.
- Derives a pixel-rate enable from the system clock with an internal divider; there is no second clock domain.

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480 @ 60 Hz by default).
// A clock divider produces a pixel-rate enable; horizontal and vertical
// counters advance on that enable, and every output is registered from the
// post-update counter values so x/y, syncs, video_on and the strobes stay
// mutually aligned.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Counters are 10 bits and the divider is 4 bits; reject geometries that
  // would silently alias.
  if (H_TOTAL - 1 > 1023 || V_TOTAL - 1 > 1023) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  logic [3:0] div_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       tick, h_wrap, v_wrap;

  assign tick   = (div_cnt == 4'(CLK_DIV - 1));
  assign h_wrap = (h_cnt == 10'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == 10'(V_TOTAL - 1));

  // Next counter values; v only moves when h wraps on a tick.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) begin
      h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= 4'd0;
    else if (tick) div_cnt <= 4'd0;
    else           div_cnt <= div_cnt + 4'd1;
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Registered outputs decoded from the post-update position, so the strobes
  // land on the same edge as the x/y change they announce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x           <= 10'd0;
      y           <= 10'd0;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_nxt;
      y           <= v_nxt;
      video_on    <= (h_nxt < 10'(H_VISIBLE)) && (v_nxt < 10'(V_VISIBLE));
      hsync       <= !((h_nxt >= 10'(HS_START)) && (h_nxt < 10'(HS_END)));
      vsync       <= !((v_nxt >= 10'(VS_START)) && (v_nxt < 10'(VS_END)));
      pixel_tick  <= tick;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so whole frames fit in a
// short run. Two instances: CLK_DIV=2 and CLK_DIV=1. A closed-form model of
// the raster position (from clocks elapsed since reset release) feeds a
// per-instance scoreboard queue; aggregate frame statistics are checked too.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 30
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FR0 = HT * VT * 2;        // frame period in clks, CLK_DIV=2
  localparam int FR1 = HT * VT;            // frame period in clks, CLK_DIV=1

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic [9:0] x0, y0, x1, y1;
  logic vo0, hs0, vs0, pt0, fs0;
  logic vo1, hs1, vs1, pt1, fs1;

  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut0 (
    .clk(clk), .reset_n(rst0_n), .x(x0), .y(y0), .video_on(vo0), .hsync(hs0),
    .vsync(vs0), .pixel_tick(pt0), .frame_start(fs0));

  vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut1 (
    .clk(clk), .reset_n(rst1_n), .x(x1), .y(y1), .video_on(vo1), .hsync(hs1),
    .vsync(vs1), .pixel_tick(pt1), .frame_start(fs1));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {x,y,video_on,hsync,vsync,pixel_tick,frame_start} after n
  // post-release clock edges.
  function automatic logic [24:0] model(input int n, input int d);
    int t, pos, ex, ey;
    logic vo, hs, vs, pt, fs;
    if (n == 0) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t   = n / d;
    pos = t % (HT * VT);
    ex  = pos % HT;
    ey  = pos / HT;
    pt  = (n % d) == 0;
    fs  = pt && (pos == 0);
    vo  = (ex < HV) && (ey < VV);
    hs  = !((ex >= HV + HF) && (ex < HV + HF + HS));
    vs  = !((ey >= VV + VF) && (ey < VV + VF + VS));
    return {10'(ex), 10'(ey), vo, hs, vs, pt, fs};
  endfunction

  logic [24:0] q0[$], q1[$];
  int n0 = 0, n1 = 0;

  // Stimulus side of the scoreboard: one expected entry per clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst0_n) n0 = 0; else n0++;
    if (!rst1_n) n1 = 0; else n1++;
    q0.push_back(model(n0, 2));
    q1.push_back(model(n1, 1));
  end

  // Frame statistics for dut0, accumulated on pixel ticks.
  int cnt_vo, cnt_hs, cnt_vs, max_vx, max_vy, bad_vo, fs0_cnt, fs1_cnt;
  int last_fs0 = -1, last_fs1 = -1;

  task automatic clear_stats();
    cnt_vo = 0; cnt_hs = 0; cnt_vs = 0; max_vx = 0; max_vy = 0; bad_vo = 0;
    fs0_cnt = 0; fs1_cnt = 0;
  endtask

  // Output side: compare on the falling edge, away from the active edge.
  initial forever begin
    logic [24:0] e;
    @(negedge clk);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0_out", {7'd0, x0, y0, vo0, hs0, vs0, pt0, fs0}, {7'd0, e});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1_out", {7'd0, x1, y1, vo1, hs1, vs1, pt1, fs1}, {7'd0, e});
    end
    if (rst0_n && pt0) begin
      if (vo0) begin
        cnt_vo++;
        if (int'(x0) > max_vx) max_vx = int'(x0);
        if (int'(y0) > max_vy) max_vy = int'(y0);
        if (!hs0 || !vs0) bad_vo++;
      end
      if (!hs0) cnt_hs++;
      if (!vs0) cnt_vs++;
    end
    if (!rst0_n) last_fs0 = -1;
    else if (fs0) begin
      fs0_cnt++;
      if (last_fs0 >= 0) check("fs0_period", cyc - last_fs0, FR0);
      last_fs0 = cyc;
    end
    if (!rst1_n) last_fs1 = -1;
    else if (fs1) begin
      fs1_cnt++;
      if (last_fs1 >= 0) check("fs1_period", cyc - last_fs1, FR1);
      last_fs1 = cyc;
    end
  end

  initial begin
    int rel_cyc;
    bit found;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    clear_stats();
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    check("rst_pixel_tick", pt0, 1'b0);
    check("rst_video_on", vo0, 1'b0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    clear_stats();

    // One full frame of dut0.
    repeat (FR0) @(posedge clk);
    @(negedge clk); #1;
    check("frame_video_on_ticks", cnt_vo, HV * VV);
    check("frame_hsync_low_ticks", cnt_hs, HS * VT);
    check("frame_vsync_low_ticks", cnt_vs, VS * HT);
    check("max_visible_x", max_vx, HV - 1);
    check("max_visible_y", max_vy, VV - 1);
    check("video_on_in_sync", bad_vo, 0);
    check("fs0_count_frame1", fs0_cnt, 1);

    // Second frame; dut1 has run four of its frames by then.
    repeat (FR0) @(negedge clk);
    #1;
    check("fs0_count_frame2", fs0_cnt, 2);
    check("fs1_count", fs1_cnt, 4);

    // Mid-frame asynchronous reset at a known raster position.
    found = 1'b0;
    for (int i = 0; i < 2 * FR0 && !found; i++) begin
      @(negedge clk);
      if (x0 == 10'd7 && y0 == 10'd10) found = 1'b1;
    end
    check("find_mid_frame", found, 1'b1);
    #2 rst0_n = 1'b0;
    #1;
    check("async_rst_x", x0, 10'd0);
    check("async_rst_y", y0, 10'd0);
    check("async_rst_syncs", {hs0, vs0}, 2'b11);
    check("async_rst_strobes", {vo0, pt0, fs0}, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst0_n = 1'b1;
    rel_cyc = cyc;
    found = 1'b0;
    for (int i = 0; i < FR0 + 10 && !found; i++) begin
      @(negedge clk);
      if (fs0) found = 1'b1;
    end
    check("fs_after_reset_seen", found, 1'b1);
    check("fs_after_reset_delay", cyc - rel_cyc, FR0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
